// File: rtl/fetch_ctrl.sv
// Program counter and one-deep fetch register for a 9-bit instruction stream.
// It drives a combinational ROM address, captures the returned word together
// with its address, and handles start/done, stall, halt and absolute or
// PC-relative redirects. A taken redirect squashes the word fetched in the
// same cycle, which costs exactly one bubble.
module fetch_ctrl #(
  parameter int D    = 12,
  parameter int OFFW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [D-1:0]    start_addr,
  input  logic            stall,
  input  logic [8:0]      mach_code,
  input  logic            halt,
  input  logic            branch_en,
  input  logic [D-1:0]    branch_target,
  input  logic            rel_en,
  input  logic [OFFW-1:0] rel_offset,
  output logic [D-1:0]    prog_ctr,
  output logic [8:0]      instr,
  output logic [D-1:0]    instr_addr,
  output logic            instr_valid,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [D-1:0]   pc_nxt;
  logic [8:0]     instr_nxt;
  logic [D-1:0]   addr_nxt;
  logic           valid_nxt;
  logic           done_nxt;

  // Offset is sign-extended to the PC width; the add then wraps naturally.
  // The offset is assumed no wider than the program counter.
  logic [D-1:0]   rel_ext;
  logic [D-1:0]   rel_target;
  logic [D-1:0]   pc_inc;

  // Redirect operands are only meaningful for a valid, on-path word.
  logic           take_halt;
  logic           take_branch;
  logic           take_rel;

  assign rel_ext    = {{(D-OFFW){rel_offset[OFFW-1]}}, rel_offset};
  assign rel_target = instr_addr + rel_ext;
  assign pc_inc     = prog_ctr + 1'b1;

  assign take_halt   = instr_valid & halt;
  assign take_branch = instr_valid & branch_en;
  assign take_rel    = instr_valid & rel_en;

  assign busy = (state == RUN);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and next register values; holding is the default everywhere.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    instr_nxt = instr;
    addr_nxt  = instr_addr;
    valid_nxt = instr_valid;
    done_nxt  = done;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = start_addr;
          valid_nxt = 1'b0;
          done_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (stall) begin
          // Decoder re-presents halt/redirects once the stall drops.
        end else if (take_halt) begin
          state_nxt = HALT;
          done_nxt  = 1'b1;
          valid_nxt = 1'b0;
        end else if (take_branch) begin
          pc_nxt    = branch_target;
          valid_nxt = 1'b0;
        end else if (take_rel) begin
          pc_nxt    = rel_target;
          valid_nxt = 1'b0;
        end else begin
          instr_nxt = mach_code;
          addr_nxt  = prog_ctr;
          valid_nxt = 1'b1;
          pc_nxt    = pc_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Program counter, fetch register and done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_ctr    <= '0;
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      prog_ctr    <= pc_nxt;
      instr       <= instr_nxt;
      instr_addr  <= addr_nxt;
      instr_valid <= valid_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed stimulus, a per-cycle reference model of
// the fetch rules checked on every falling edge, plus literal expectations.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  localparam int D    = 12;
  localparam int OFFW = 8;
  localparam int NW   = 1 << D;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [D-1:0]    start_addr;
  logic            stall;
  logic [8:0]      mach_code;
  logic            halt;
  logic            branch_en;
  logic [D-1:0]    branch_target;
  logic            rel_en;
  logic [OFFW-1:0] rel_offset;
  logic [D-1:0]    prog_ctr;
  logic [8:0]      instr;
  logic [D-1:0]    instr_addr;
  logic            instr_valid;
  logic            busy;
  logic            done;

  logic [8:0] rom [NW];

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(.D(D), .OFFW(OFFW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .stall(stall), .mach_code(mach_code), .halt(halt),
    .branch_en(branch_en), .branch_target(branch_target),
    .rel_en(rel_en), .rel_offset(rel_offset),
    .prog_ctr(prog_ctr), .instr(instr), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign mach_code = rom[prog_ctr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running/done flags, PC and the fetch register.
  bit       m_running, m_done, m_valid;
  int       m_pc, m_instr, m_addr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_running = 0; m_done = 0; m_valid = 0;
      m_pc = 0; m_instr = 0; m_addr = 0;
    end else if (!m_running) begin
      if (start) begin
        m_pc = int'(start_addr); m_running = 1; m_done = 0; m_valid = 0;
      end
    end else if (stall) begin
      // frozen
    end else if (m_valid && halt) begin
      m_running = 0; m_done = 1; m_valid = 0;
    end else if (m_valid && branch_en) begin
      m_pc = int'(branch_target); m_valid = 0;
    end else if (m_valid && rel_en) begin
      m_pc = (m_addr + int'($signed(rel_offset))) & (NW - 1); m_valid = 0;
    end else begin
      m_instr = int'(rom[m_pc]); m_addr = m_pc; m_valid = 1;
      m_pc = (m_pc + 1) % NW;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("model_prog_ctr",    int'(prog_ctr),    m_pc);
    chk("model_instr_valid", int'(instr_valid), int'(m_valid));
    chk("model_busy",        int'(busy),        int'(m_running));
    chk("model_done",        int'(done),        int'(m_done));
    chk("model_instr_addr",  int'(instr_addr),  m_addr);
    chk("model_instr",       int'(instr),       m_instr);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int a = 0; a < NW; a++) rom[a] = 9'((a * 37 + 11) & 9'h1FF);
    rom[12'h010] = 9'h0A1;
    rom[12'h011] = 9'h0B2;
    rom[12'h012] = 9'h0C3;
    rom[12'h100] = 9'h155;

    reset = 1; start = 0; start_addr = '0; stall = 0; halt = 0;
    branch_en = 0; branch_target = '0; rel_en = 0; rel_offset = '0;
    step(); step();
    chk("rst_pc", int'(prog_ctr), 0);
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_busy_done", int'({busy, done}), 0);
    reset = 0;

    // Start at 0x010 and fetch three words.
    start = 1; start_addr = 12'h010;
    step(); start = 0;
    chk("start_pc", int'(prog_ctr), 'h010);
    chk("start_busy", int'(busy), 1);
    step();
    chk("seq0_instr", int'(instr), 'h0A1);
    chk("seq0_addr", int'(instr_addr), 'h010);
    step();
    chk("seq1_instr", int'(instr), 'h0B2);
    step();
    chk("seq2_instr", int'(instr), 'h0C3);
    chk("seq2_valid_done", int'({instr_valid, done}), 'b10);

    // Go back to 0x011, then branch to 0x100 while 0x011 is valid.
    branch_en = 1; branch_target = 12'h011;
    step(); branch_en = 0;
    chk("bubble_a_valid", int'(instr_valid), 0);
    step();
    chk("at011_addr", int'(instr_addr), 'h011);
    branch_en = 1; branch_target = 12'h100;
    step(); branch_en = 0;
    chk("br_squash_valid", int'(instr_valid), 0);
    chk("br_pc", int'(prog_ctr), 'h100);
    step();
    chk("br_target_instr", int'(instr), 'h155);
    chk("br_target_valid", int'(instr_valid), 1);

    // branch_en and rel_en together: absolute wins.
    branch_en = 1; branch_target = 12'h200; rel_en = 1; rel_offset = 8'h10;
    step(); branch_en = 0; rel_en = 0;
    chk("both_pc", int'(prog_ctr), 'h200);
    step();

    // Relative redirect from 0x002 by -5 wraps to 0xFFD.
    branch_en = 1; branch_target = 12'h002;
    step(); branch_en = 0;
    step();
    chk("at002_addr", int'(instr_addr), 'h002);
    rel_en = 1; rel_offset = 8'hFB;
    step();
    chk("rel_pc", int'(prog_ctr), 'hFFD);
    chk("rel_bubble", int'(instr_valid), 0);
    step(); rel_en = 0;               // rel_en ignored while instr_valid=0
    chk("rel_target_addr", int'(instr_addr), 'hFFD);
    chk("rel_ignored_pc", int'(prog_ctr), 'hFFE);
    step();
    chk("pc_fff", int'(prog_ctr), 'hFFF);
    step();
    chk("pc_wrap", int'(prog_ctr), 'h000);
    step();

    // Stall three cycles with a branch pending.
    stall = 1; branch_en = 1; branch_target = 12'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", int'(prog_ctr), 'h001);
      chk("stall_addr", int'(instr_addr), 'h000);
      chk("stall_instr", int'(instr), 'h00B);
      chk("stall_valid", int'(instr_valid), 1);
    end
    stall = 0;
    step(); branch_en = 0;
    chk("post_stall_br_pc", int'(prog_ctr), 'h300);
    step();

    // Halt, idle ten cycles, restart from 0.
    halt = 1;
    step(); halt = 0;
    chk("halt_busy_done_valid", int'({busy, done, instr_valid}), 'b010);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_hold", int'({busy, done}), 'b01);
    end
    start = 1; start_addr = 12'h000;
    step(); start = 0;
    chk("restart_done", int'(done), 0);
    chk("restart_pc", int'(prog_ctr), 0);
    step();
    start = 1; start_addr = 12'h555;   // ignored while running
    step(); start = 0;
    chk("run_start_ignored", int'(prog_ctr), 'h002);
    step();

    // Asynchronous reset between edges.
    reset = 1;
    #1;
    chk("arst_pc", int'(prog_ctr), 0);
    chk("arst_instr", int'(instr), 0);
    chk("arst_addr", int'(instr_addr), 0);
    chk("arst_flags", int'({instr_valid, busy, done}), 0);
    step(); reset = 0;
    step(); step(); step();
    chk("idle_after_rst", int'({busy, prog_ctr}), 0);
    start = 1; start_addr = 12'h7F0;
    step(); start = 0;
    step(); step();
    chk("resume_addr", int'(instr_addr), 'h7F1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Program-counter and fetch stage that drives the instruction ROM address and registers the returned 9-bit machine word into a one-deep fetch register for the decoder. It handles the start/done handshake with the testbench and sequential fetch. It also handles absolute and PC-relative redirects, squashing the wrong-path word. Stall and halt requests come back from the decode/execute stage.

Parameters:
D, 12, program-counter width; the ROM holds 2**D words.
OFFW, 8, width of the signed relative branch offset.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin execution at start_addr; sampled in IDLE/HALT only
start_addr  input  D  first fetch address
stall  input  1  hold fetch register and PC this cycle
mach_code  input  9  ROM word at prog_ctr (combinational ROM read)
halt  input  1  decoder saw halt in instr; qualified by instr_valid
branch_en  input  1  absolute redirect taken; qualified by instr_valid
branch_target  input  D  absolute redirect address
rel_en  input  1  relative redirect taken; qualified by instr_valid
rel_offset  input  OFFW  signed two's-complement offset from instr_addr
prog_ctr  output  D  ROM address (registered)
instr  output  9  registered machine word
instr_addr  output  D  address instr was fetched from
instr_valid  output  1  instr is on the correct path and executable
busy  output  1  high in RUN
done  output  1  high from halt until next start

Behaviour:
- Reset value: state=IDLE, prog_ctr=0, instr=0, instr_addr=0, instr_valid=0, done=0. Mid-operation reset returns to these values at once, regardless of clk.
- States are IDLE, RUN and HALT. busy=(state==RUN), decoded straight from the state register.
- IDLE/HALT with start=1: the next edge gives prog_ctr<=start_addr, state<=RUN, done<=0, instr_valid<=0.
- IDLE/HALT with start=0: all registers hold. In HALT, done stays 1.
- RUN, start is ignored. Per edge, first matching case wins:
  1. stall=1: every register holds, including instr_valid. halt/branch inputs are ignored; the decoder re-presents them after stall.
  2. instr_valid & halt: state<=HALT, done<=1, instr_valid<=0, prog_ctr holds.
  3. instr_valid & branch_en: prog_ctr<=branch_target, instr_valid<=0. The word fetched this cycle is squashed.
  4. instr_valid & rel_en: prog_ctr<=instr_addr + sign_ext(rel_offset) mod 2**D, instr_valid<=0.
  5. Otherwise: instr<=mach_code, instr_addr<=prog_ctr, instr_valid<=1, prog_ctr<=prog_ctr+1 mod 2**D.
- Redirect inputs with instr_valid=0 are ignored.
- If branch_en and rel_en are both high, branch_en wins.
- Fetch latency: a word appears in instr one edge after its address is on prog_ctr.
- Redirect penalty: exactly one bubble cycle (instr_valid=0) before the target word becomes valid.
- Wrap-around: prog_ctr at 2**D-1 increments to 0. Relative targets wrap modulo 2**D, e.g. instr_addr=2, offset=-5 gives 2**D-3.
- instr is not cleared on squash or halt. Consumers must gate on instr_valid.
- done is a level, not a pulse.

Test Plan:
- Reset then start: reset=1, then start=1 with start_addr=0x010, ROM[0x010..0x012]=0x0A1,0x0B2,0x0C3. Required: cycles 2-4 show instr=0x0A1,0x0B2,0x0C3 with instr_addr 0x010..0x012, instr_valid=1, busy=1, done=0.
- Absolute branch: branch_en=1 with target 0x100 while instr_addr=0x011 is valid. Required: the next cycle has instr_valid=0 (squash) and prog_ctr=0x100, and the cycle after that has instr=ROM[0x100] valid.
- Relative branch with wrap: instr_addr=0x002, rel_offset=8'hFB (-5). Required: prog_ctr becomes 0xFFD after one bubble. Also, prog_ctr=0xFFF with sequential fetch must advance to 0x000.
- Stall: stall=1 for 3 cycles mid-run. Required: prog_ctr, instr, instr_addr and instr_valid are frozen. A branch_en raised during the stall has no effect until stall drops.
- Halt and restart: halt=1 with valid instr. Required: busy=0, done=1 and instr_valid=0 next cycle, held for 10 idle cycles. Then start with start_addr=0 must clear done and resume fetch from 0.
- Async reset mid-run: assert reset between clock edges during RUN. Required: all outputs go to their reset values immediately, and start is needed again to resume.
